accelerator_trainer_fnn_matrix_scanner: RTL and testbench
=========================================================

# accelerator_trainer_fnn_matrix_scanner

Read sequencer directly upstream of the FNN trainer's matrix input ports. On a start pulse it scans an I×J matrix held in a synchronous-read buffer and presents one element at a time, marking each row start. Its enables drive the trainer's paired row/element enable inputs, e.g. W_IN_L_ENABLE/W_IN_X_ENABLE or K_IN_I/K_IN_K. Consumer backpressure stalls the scan.

## Interface
- DATA_SIZE, 64, element and size-word width
- ADDRESS_SIZE, 16, buffer address width
- CLK  in  1  single clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- START  in  1  begin a scan; sampled only in IDLE
- READY  out  1  high in IDLE
- DONE  out  1  one-cycle pulse when a scan finishes
- SIZE_I_IN  in  DATA_SIZE  row count, captured at START
- SIZE_J_IN  in  DATA_SIZE  column count, captured at START
- TRANSPOSE  in  1  column-major scan request, captured at START (see Configuration)
- MEM_ADDRESS  out  ADDRESS_SIZE  buffer read address
- MEM_DATA  in  DATA_SIZE  buffer read data, valid one cycle after address
- DATA_OUT  out  DATA_SIZE  current element
- DATA_I_ENABLE  out  1  high with the first element of each outer-loop line
- DATA_J_ENABLE  out  1  element valid
- DATA_ACCEPT  in  1  consumer takes element when DATA_J_ENABLE && DATA_ACCEPT

## Operation
- FSM states: IDLE, FETCH, LOAD, PRESENT.
- IDLE to FETCH on START with both sizes nonzero. Outer count, inner count and address are zeroed.
- START in IDLE with either size zero: stay in IDLE and pulse DONE the next cycle. No enables are asserted.
- FETCH drives MEM_ADDRESS, then goes to LOAD.
- LOAD registers MEM_DATA into DATA_OUT, then goes to PRESENT.
- PRESENT holds DATA_J_ENABLE=1. DATA_I_ENABLE=1 when the inner index is 0. DATA_OUT is stable until accept.
- On accept in PRESENT:
  - If not the last inner element: inner+1, address+1, go to FETCH.
  - If the last inner element but not the last outer line: inner=0, outer+1, go to FETCH.
  - If the last element overall: go to IDLE and pulse DONE.
- Row-major order: outer=i (SIZE_I lines), inner=j (SIZE_J elements), address = i*SIZE_J + j. Built from a running +1 counter; no multiplier.
- All counters are DATA_SIZE wide. Address arithmetic wraps modulo 2^ADDRESS_SIZE.
- START outside IDLE is ignored. SIZE_* changes mid-scan are ignored.
- DATA_ACCEPT outside PRESENT is ignored.

## Timing
- Reset values: READY=1, DONE=0, DATA_OUT=0, DATA_I_ENABLE=0, DATA_J_ENABLE=0, MEM_ADDRESS=0. State=IDLE, counters=0.
- RST low at any edge, including mid-scan: reset values at the next cycle. No DONE pulse is issued.
- START high at edge k:
  - k+1: FETCH, READY=0
  - k+2: LOAD
  - k+3: PRESENT with the first element
- Minimum 3 cycles per element, plus stall cycles while DATA_ACCEPT is low.
- DONE is high exactly one cycle after the final accept, simultaneous with READY returning to 1.
- A START arriving in the same cycle DONE is high is sampled, because the block is already in IDLE.

## Configuration
- Macro: ACCELERATOR_TRAINER_FNN_MATRIX_SCANNER_TRANSPOSE_EN.
- Defined: TRANSPOSE=1 at START selects column-major order.
  - Outer=j (SIZE_J lines), inner=i (SIZE_I elements).
  - The inner step adds SIZE_J to the address.
  - On an outer wrap, the address is set to the new j.
  - DATA_I_ENABLE marks the first element of each column.
- Undefined: the TRANSPOSE port exists but is ignored; the scan is always row-major.

## Test plan
- SIZE_I=2, SIZE_J=3, MEM[a]=a+100, DATA_ACCEPT tied 1:
  - DATA_OUT sequence 100..105.
  - DATA_I_ENABLE with 100 and 103.
  - Element spacing 3 cycles; DONE 1 cycle after accepting 105.
- Same setup, DATA_ACCEPT low for 5 cycles on element 102: DATA_OUT and enables held 5 extra cycles, no duplicate or skipped elements.
- SIZE_I=0, SIZE_J=4, START: DONE pulses the next cycle, READY never drops, no enables.
- RST low during the third PRESENT of a 2×3 scan: all outputs at reset values the next cycle. A new START then restarts from address 0.
- START re-pulsed mid-scan, and SIZE_J changed to 7 mid-scan: ignored; the original 6-element sequence completes.
- With TRANSPOSE_EN defined, TRANSPOSE=1, SIZE_I=2, SIZE_J=3:
  - Address sequence 0,3,1,4,2,5.
  - DATA_I_ENABLE with addresses 0, 1, 2.
  - With the macro undefined, the same stimulus gives 0..5.

Source files
------------

// File: rtl/accelerator_trainer_fnn_matrix_scanner.sv
// Matrix read sequencer: scans an I x J buffer one element at a time with row-start marking and consumer backpressure.
// Optional column-major scan enabled by ACCELERATOR_TRAINER_FNN_MATRIX_SCANNER_TRANSPOSE_EN.
module accelerator_trainer_fnn_matrix_scanner #(
    parameter int DATA_SIZE    = 64,
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    DONE,
    input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
    input  logic                    TRANSPOSE,
    output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
    input  logic [DATA_SIZE-1:0]    MEM_DATA,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    DATA_I_ENABLE,
    output logic                    DATA_J_ENABLE,
    input  logic                    DATA_ACCEPT
);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PRESENT} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_SIZE-1:0]    size_i;
    logic [DATA_SIZE-1:0]    size_j;
    logic [DATA_SIZE-1:0]    outer_cnt;
    logic [DATA_SIZE-1:0]    inner_cnt;
    logic [ADDRESS_SIZE-1:0] address;
    logic [DATA_SIZE-1:0]    data_r;
    logic                    done_r;
    logic                    col_major;

    logic                    start_ok;
    logic                    last_inner;
    logic                    last_outer;
    logic [DATA_SIZE-1:0]    inner_inc;
    logic [DATA_SIZE-1:0]    outer_inc;
    logic [DATA_SIZE-1:0]    inner_lim;
    logic [DATA_SIZE-1:0]    outer_lim;

`ifdef ACCELERATOR_TRAINER_FNN_MATRIX_SCANNER_TRANSPOSE_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            col_major <= 1'b0;
        end else if (state == IDLE && start_ok) begin
            col_major <= TRANSPOSE;
        end
    end
`else
    logic unused_transpose;
    assign unused_transpose = TRANSPOSE;
    assign col_major        = 1'b0;
`endif

    assign start_ok   = START && (SIZE_I_IN != '0) && (SIZE_J_IN != '0);
    assign inner_inc  = inner_cnt + DATA_SIZE'(1);
    assign outer_inc  = outer_cnt + DATA_SIZE'(1);
    // Column-major swaps which dimension forms the lines.
    assign inner_lim  = col_major ? size_i : size_j;
    assign outer_lim  = col_major ? size_j : size_i;
    assign last_inner = (inner_inc == inner_lim);
    assign last_outer = (outer_inc == outer_lim);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = FETCH;
            FETCH:   state_next = LOAD;
            LOAD:    state_next = PRESENT;
            PRESENT: if (DATA_ACCEPT) state_next = (last_inner && last_outer) ? IDLE : FETCH;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            size_i    <= '0;
            size_j    <= '0;
            outer_cnt <= '0;
            inner_cnt <= '0;
            address   <= '0;
            data_r    <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        size_i    <= SIZE_I_IN;
                        size_j    <= SIZE_J_IN;
                        outer_cnt <= '0;
                        inner_cnt <= '0;
                        address   <= '0;
                    end else if (START) begin
                        done_r <= 1'b1;
                    end
                end
                LOAD: data_r <= MEM_DATA;
                PRESENT: begin
                    if (DATA_ACCEPT) begin
                        if (!last_inner) begin
                            inner_cnt <= inner_inc;
                            address   <= col_major ? address + size_j[ADDRESS_SIZE-1:0]
                                                   : address + ADDRESS_SIZE'(1);
                        end else if (!last_outer) begin
                            inner_cnt <= '0;
                            outer_cnt <= outer_inc;
                            // Row-major lines are contiguous; a new column starts at its own index.
                            address   <= col_major ? outer_inc[ADDRESS_SIZE-1:0]
                                                   : address + ADDRESS_SIZE'(1);
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign READY         = (state == IDLE);
    assign DONE          = done_r;
    assign MEM_ADDRESS   = address;
    assign DATA_OUT      = data_r;
    assign DATA_J_ENABLE = (state == PRESENT);
    assign DATA_I_ENABLE = (state == PRESENT) && (inner_cnt == '0);

endmodule

// File: tb/tb_accelerator_trainer_fnn_matrix_scanner.sv
// Directed and randomized bench for the matrix scanner, checked against an index-loop reference model.
module tb_accelerator_trainer_fnn_matrix_scanner;

    localparam int DW = 64;
    localparam int AW = 16;
`ifdef ACCELERATOR_TRAINER_FNN_MATRIX_SCANNER_TRANSPOSE_EN
    localparam bit TR_EN = 1'b1;
`else
    localparam bit TR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ready;
    logic          done;
    logic [DW-1:0] size_i_in;
    logic [DW-1:0] size_j_in;
    logic          transpose;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] data_out;
    logic          data_i_enable;
    logic          data_j_enable;
    logic          data_accept;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [DW-1:0] mem [256];

    accelerator_trainer_fnn_matrix_scanner #(.DATA_SIZE(DW), .ADDRESS_SIZE(AW)) dut (
        .CLK(clk), .RST(rst), .START(start), .READY(ready), .DONE(done),
        .SIZE_I_IN(size_i_in), .SIZE_J_IN(size_j_in), .TRANSPOSE(transpose),
        .MEM_ADDRESS(mem_address), .MEM_DATA(mem_data), .DATA_OUT(data_out),
        .DATA_I_ENABLE(data_i_enable), .DATA_J_ENABLE(data_j_enable),
        .DATA_ACCEPT(data_accept)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_data <= mem[mem_address[7:0]];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 64'(ready), 64'(1));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_data"}, data_out, 64'(0));
        check({tag, "_i_en"}, 64'(data_i_enable), 64'(0));
        check({tag, "_j_en"}, 64'(data_j_enable), 64'(0));
        check({tag, "_addr"}, 64'(mem_address), 64'(0));
    endtask

    task automatic run_zero(input int si, input int sj);
        @(negedge clk);
        size_i_in = DW'(si); size_j_in = DW'(sj); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done", 64'(done), 64'(1));
        check("zero_ready", 64'(ready), 64'(1));
        check("zero_j_en", 64'(data_j_enable), 64'(0));
        check("zero_i_en", 64'(data_i_enable), 64'(0));
        @(negedge clk);
        check("zero_done_clear", 64'(done), 64'(0));
        check("zero_ready2", 64'(ready), 64'(1));
    endtask

    // Reference order comes straight from the i/j nested loops with address i*J+j.
    task automatic run_scan(input int si, input int sj, input bit tr, input bit rnd,
                            input int stall_idx, input int stall_len, input bit disturb,
                            input int abort_idx);
        int addr_q[$];
        bit first_q[$];
        int prev, exp_gap, waitc, len, total;
        bit col;
        col = tr && TR_EN;
        if (col) begin
            for (int j = 0; j < sj; j++)
                for (int i = 0; i < si; i++) begin
                    addr_q.push_back(i * sj + j);
                    first_q.push_back(i == 0);
                end
        end else begin
            for (int i = 0; i < si; i++)
                for (int j = 0; j < sj; j++) begin
                    addr_q.push_back(i * sj + j);
                    first_q.push_back(j == 0);
                end
        end
        total = addr_q.size();
        @(negedge clk);
        size_i_in = DW'(si); size_j_in = DW'(sj); transpose = tr; start = 1'b1;
        prev = cyc;
        @(negedge clk);
        start = 1'b0;
        check("fetch_ready", 64'(ready), 64'(0));
        check("first_addr", 64'(mem_address), 64'(addr_q[0]));
        exp_gap = 3;
        for (int n = 0; n < total; n++) begin
            waitc = 0;
            while (!data_j_enable && waitc < 30) begin
                if (rnd) data_accept = 1'($urandom_range(0, 1));
                @(negedge clk);
                waitc++;
            end
            if (!data_j_enable) begin
                check("present_timeout", 64'(0), 64'(1));
                return;
            end
            check("data", data_out, mem[addr_q[n]]);
            check("i_en", 64'(data_i_enable), 64'(first_q[n]));
            check("gap", 64'(cyc - prev), 64'(exp_gap));
            prev = cyc;
            if (n == abort_idx) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check_idle_outputs("abort");
                @(negedge clk);
                check("abort_no_done", 64'(done), 64'(0));
                check("abort_ready", 64'(ready), 64'(1));
                return;
            end
            len = rnd ? $urandom_range(0, 3) : ((n == stall_idx) ? stall_len : 0);
            if (disturb && n == 2) begin
                start = 1'b1;
                size_j_in = DW'(7);
            end
            if (len > 0) begin
                data_accept = 1'b0;
                repeat (len) begin
                    @(negedge clk);
                    check("hold_data", data_out, mem[addr_q[n]]);
                    check("hold_j_en", 64'(data_j_enable), 64'(1));
                    check("hold_i_en", 64'(data_i_enable), 64'(first_q[n]));
                end
            end
            data_accept = 1'b1;
            @(negedge clk);
            start = 1'b0;
            exp_gap = 3 + len;
            if (n < total - 1) begin
                check("next_addr", 64'(mem_address), 64'(addr_q[n+1]));
                check("fetch_j_off", 64'(data_j_enable), 64'(0));
                check("early_done", 64'(done), 64'(0));
            end else begin
                check("done", 64'(done), 64'(1));
                check("done_ready", 64'(ready), 64'(1));
                check("done_j_off", 64'(data_j_enable), 64'(0));
                @(negedge clk);
                check("done_clear", 64'(done), 64'(0));
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; size_i_in = '0; size_j_in = '0;
        transpose = 1'b0; data_accept = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = DW'(a + 100);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("idle");

        run_scan(2, 3, 1'b0, 1'b0, -1, 0, 1'b0, -1);
        run_scan(2, 3, 1'b0, 1'b0, 2, 5, 1'b0, -1);
        run_zero(0, 4);
        run_zero(3, 0);
        run_scan(2, 3, 1'b0, 1'b0, -1, 0, 1'b0, 2);
        run_scan(2, 3, 1'b0, 1'b0, -1, 0, 1'b0, -1);
        run_scan(2, 3, 1'b0, 1'b0, -1, 0, 1'b1, -1);
        run_scan(2, 3, 1'b1, 1'b0, -1, 0, 1'b0, -1);

        for (int k = 0; k < 12; k++) begin
            for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
            run_scan($urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                     1'b1, -1, 0, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
